// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit bus owner: power-up init, then two-port write arbitration with hold-lock.
// Optional macro LCD_SCHED_ROUND_ROBIN_EN swaps fixed port-0 priority for round-robin ties.
module lcd_bus_scheduler #(
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_HIGH_CYC    = 12,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] REQ0_DATA,
  input  logic       REQ0_ENB,
  input  logic       REQ0_HOLD,
  output logic       REQ0_RDY,
  input  logic [9:0] REQ1_DATA,
  input  logic       REQ1_ENB,
  input  logic       REQ1_HOLD,
  output logic       REQ1_RDY,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic       INIT_DONE,
  output logic       ERR
);

  localparam int unsigned MaxAB  = (PWRUP_CYC > LONG_WAIT_CYC) ? PWRUP_CYC : LONG_WAIT_CYC;
  localparam int unsigned MaxCD  = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
  localparam int unsigned MaxCDS = (MaxCD > SETUP_CYC) ? MaxCD : SETUP_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCDS) ? MaxAB : MaxCDS;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] PwrupLd = CntW'(PWRUP_CYC - 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] EHighLd = CntW'(E_HIGH_CYC - 1);
  localparam logic [CntW-1:0] CmdLd   = CntW'(CMD_WAIT_CYC - 1);
  localparam logic [CntW-1:0] LongLd  = CntW'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {StPwrup, StInit, StIdle, StSetup, StPulse, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][9:0] slot_q, slot_d;
  logic            src_q, src_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic            rs_q, rs_d;
  logic [7:0]      db_q, db_d;
  logic            own_vld_q, own_vld_d;
  logic            own_q, own_d;
  logic            tie_sel;

  logic [1:0]      req_enb, req_hold, rdy;
  logic [1:0][9:0] req_data;
  logic            own_rel, own_live, sel_vld, sel;

  assign req_enb  = {REQ1_ENB, REQ0_ENB};
  assign req_hold = {REQ1_HOLD, REQ0_HOLD};
  assign req_data = {REQ1_DATA, REQ0_DATA};
  assign rdy      = {2{init_done_q}} & ~full_q;

  function automatic logic [7:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_word = 8'h38;
      3'd3:             init_word = 8'h0C;
      3'd4:             init_word = 8'h01;
      default:          init_word = 8'h06;
    endcase
  endfunction

`ifdef LCD_SCHED_ROUND_ROBIN_EN
  // rr_q holds the port preferred on the next tie, i.e. the one not served last.
  logic rr_q, rr_d;
  assign tie_sel = rr_q;
`else
  assign tie_sel = 1'b0;
`endif

  // Ownership lapses once the owner lets go of HOLD and has nothing queued.
  assign own_rel  = own_vld_q && !req_hold[own_q] && !full_q[own_q];
  assign own_live = own_vld_q && !own_rel;

  always_comb begin
    sel_vld = 1'b0;
    sel     = 1'b0;
    if (own_live) begin
      sel_vld = full_q[own_q];
      sel     = own_q;
    end else if (full_q == 2'b11) begin
      sel_vld = 1'b1;
      sel     = tie_sel;
    end else begin
      sel_vld = |full_q;
      sel     = full_q[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    slot_d      = slot_q;
    src_d       = src_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    rs_d        = rs_q;
    db_d        = db_q;
    own_vld_d   = own_vld_q;
    own_d       = own_q;
`ifdef LCD_SCHED_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif

    for (int i = 0; i < 2; i++) begin
      if (req_enb[i] && rdy[i]) begin
        full_d[i] = 1'b1;
        slot_d[i] = req_data[i];
      end
    end

    unique case (state_q)
      StPwrup: begin
        if (cnt_q == '0) state_d = StInit;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StInit: begin
        rs_d    = 1'b0;
        db_d    = init_word(init_idx_q);
        cnt_d   = SetupLd;
        state_d = StSetup;
      end
      StIdle: begin
        if (own_rel) own_vld_d = 1'b0;
        if (sel_vld) begin
          if (slot_q[sel][8]) begin
            // Read-flagged words are dropped without touching the bus.
            full_d[sel] = 1'b0;
            err_d       = 1'b1;
          end else begin
            rs_d    = slot_q[sel][9];
            db_d    = slot_q[sel][7:0];
            src_d   = sel;
            cnt_d   = SetupLd;
            state_d = StSetup;
            if (req_hold[sel]) begin
              own_vld_d = 1'b1;
              own_d     = sel;
            end
`ifdef LCD_SCHED_ROUND_ROBIN_EN
            rr_d = ~sel;
`endif
          end
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = EHighLd;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          cnt_d   = (!rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03)) ? LongLd : CmdLd;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (init_done_q) begin
          full_d[src_q] = 1'b0;
          state_d       = StIdle;
        end else if (init_idx_q == 3'd5) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = StInit;
        end
      end
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StPwrup;
      cnt_q       <= PwrupLd;
      full_q      <= '0;
      slot_q      <= '0;
      src_q       <= 1'b0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= '0;
      own_vld_q   <= 1'b0;
      own_q       <= 1'b0;
`ifdef LCD_SCHED_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      slot_q      <= slot_d;
      src_q       <= src_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      own_vld_q   <= own_vld_d;
      own_q       <= own_d;
`ifdef LCD_SCHED_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign REQ0_RDY  = rdy[0];
  assign REQ1_RDY  = rdy[1];
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_E     = (state_q == StPulse);
  assign LCD_DB    = db_q;
  assign INIT_DONE = init_done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: init sequence, handshake timing, hold-lock,
// tie-break, read-flag discard, mid-pulse reset, plus randomized single-word traffic.
module tb_lcd_bus_scheduler;

  localparam int unsigned PwrupCyc    = 20;
  localparam int unsigned SetupCyc    = 1;
  localparam int unsigned EHighCyc    = 2;
  localparam int unsigned CmdWaitCyc  = 4;
  localparam int unsigned LongWaitCyc = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic       REQ0_ENB = 1'b0, REQ1_ENB = 1'b0, REQ0_HOLD = 1'b0, REQ1_HOLD = 1'b0;
  logic       REQ0_RDY, REQ1_RDY, LCD_RS, LCD_RW, LCD_E, INIT_DONE, ERR;
  logic [7:0] LCD_DB;

  lcd_bus_scheduler #(
    .PWRUP_CYC    (PwrupCyc),
    .SETUP_CYC    (SetupCyc),
    .E_HIGH_CYC   (EHighCyc),
    .CMD_WAIT_CYC (CmdWaitCyc),
    .LONG_WAIT_CYC(LongWaitCyc)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ0_DATA(REQ0_DATA),
    .REQ0_ENB (REQ0_ENB),
    .REQ0_HOLD(REQ0_HOLD),
    .REQ0_RDY (REQ0_RDY),
    .REQ1_DATA(REQ1_DATA),
    .REQ1_ENB (REQ1_ENB),
    .REQ1_HOLD(REQ1_HOLD),
    .REQ1_RDY (REQ1_RDY),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E),
    .LCD_DB   (LCD_DB),
    .INIT_DONE(INIT_DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         start;
    int         fall;
  } pulse_t;

  pulse_t     pulses[$];
  logic       e_prev = 1'b0;
  logic       rise_rs = 1'b0;
  logic [7:0] rise_db = '0;
  int         rise_cyc = 0;

  // Bus monitor: one record per E pulse, start = first high cycle, fall = first low cycle.
  always @(negedge CLK) begin
    e_prev <= LCD_E;
    if (LCD_E && !e_prev) begin
      rise_rs  <= LCD_RS;
      rise_db  <= LCD_DB;
      rise_cyc <= cyc;
    end
    if (!LCD_E && e_prev) pulses.push_back('{rs: rise_rs, db: rise_db, start: rise_cyc, fall: cyc});
  end

  int   n_chk = 0;
  int   n_err = 0;
  logic err_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] db);
    if (!rs && (db == 8'h01 || db == 8'h02 || db == 8'h03)) return LongWaitCyc;
    return CmdWaitCyc;
  endfunction

  function automatic logic [7:0] exp_init(input int i);
    case (i)
      3:       return 8'h0C;
      4:       return 8'h01;
      5:       return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  function automatic logic port_rdy(input int port);
    return (port == 1) ? REQ1_RDY : REQ0_RDY;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(REQ0_RDY && REQ1_RDY) && n < 500) begin step(); n++; end
    if (n >= 500) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic wait_pulses(input int cnt);
    int n = 0;
    while (pulses.size() < cnt && n < 300) begin step(); n++; end
    if (n >= 300) check_eq("pulse_timeout", pulses.size(), cnt);
  endtask

  task automatic push_word(input int port, input logic [9:0] w, output int acc);
    int n = 0;
    while (!port_rdy(port) && n < 500) begin step(); n++; end
    if (n >= 500) check_eq("rdy_timeout", 0, 1);
    if (port == 1) begin REQ1_DATA = w; REQ1_ENB = 1'b1; end
    else           begin REQ0_DATA = w; REQ0_ENB = 1'b1; end
    acc = cyc;
    step();
    REQ0_ENB = 1'b0;
    REQ1_ENB = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input int idx, input logic rs, input logic [7:0] db);
    if (idx < pulses.size()) begin
      check_eq({tag, "_rs"}, pulses[idx].rs, rs);
      check_eq({tag, "_db"}, pulses[idx].db, db);
    end else begin
      check_eq({tag, "_missing"}, pulses.size(), idx + 1);
    end
  endtask

  // One word on an idle bus, checked against the timing rules.
  task automatic send_checked(input int port, input logic [9:0] w);
    int acc, low;
    pulse_t p;
    wait_idle();
    pulses.delete();
    push_word(port, w, acc);
    low = 0;
    while (!port_rdy(port) && low < 500) begin low++; step(); end
    if (w[8]) begin
      err_seen = 1'b1;
      check_eq("bad_no_pulse", pulses.size(), 0);
      check_eq("bad_rdy_low", low, 1);
    end else begin
      check_eq("pulse_cnt", pulses.size(), 1);
      if (pulses.size() > 0) begin
        p = pulses.pop_front();
        check_eq("pulse_rs", p.rs, w[9]);
        check_eq("pulse_db", p.db, w[7:0]);
        check_eq("e_latency", p.start - acc, 2 + SetupCyc);
        check_eq("e_width", p.fall - p.start, EHighCyc);
      end
      check_eq("rdy_low", low, 1 + SetupCyc + EHighCyc + wait_of(w[9], w[7:0]));
    end
    check_eq("err_flag", ERR, err_seen);
    check_eq("rw_low", LCD_RW, 0);
    pulses.delete();
  endtask

  task automatic check_init(input int r);
    int n = 0;
    int done_cyc;
    while (!INIT_DONE && n < 3000) begin step(); n++; end
    if (n >= 3000) check_eq("init_timeout", 0, 1);
    done_cyc = cyc;
    check_eq("init_pulses", pulses.size(), 6);
    if (pulses.size() > 0) check_eq("init_first_e", pulses[0].start, r + PwrupCyc + 1 + SetupCyc);
    for (int i = 0; i < 6 && i < pulses.size(); i++) begin
      check_eq($sformatf("init_db%0d", i), pulses[i].db, exp_init(i));
      check_eq($sformatf("init_rs%0d", i), pulses[i].rs, 0);
      check_eq($sformatf("init_w%0d", i), pulses[i].fall - pulses[i].start, EHighCyc);
      if (i < 5 && i + 1 < pulses.size())
        check_eq($sformatf("init_gap%0d", i), pulses[i + 1].start - pulses[i].fall,
                 wait_of(1'b0, exp_init(i)) + 1 + SetupCyc);
    end
    if (pulses.size() == 6) check_eq("init_done_time", done_cyc, pulses[5].fall + CmdWaitCyc);
    check_eq("init_rdy0", REQ0_RDY, 1);
    check_eq("init_rdy1", REQ1_RDY, 1);
    check_eq("init_err", ERR, 0);
    pulses.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, r;
    logic [9:0] w;
    #2 RST = 1'b1;
    step(); step();
    check_eq("rst_e", LCD_E, 0);
    check_eq("rst_rs", LCD_RS, 0);
    check_eq("rst_db", LCD_DB, 0);
    check_eq("rst_done", INIT_DONE, 0);
    check_eq("rst_rdy", {REQ1_RDY, REQ0_RDY}, 0);
    check_eq("rst_err", ERR, 0);
    RST = 1'b0;
    r = cyc;
    pulses.delete();
    check_init(r);

    send_checked(0, 10'h241);

    // Hold-lock: port 1 must wait until port 0 drops HOLD.
    wait_idle();
    pulses.delete();
    REQ0_HOLD = 1'b1;
    push_word(0, 10'h0C0, acc);
    push_word(1, 10'h201, acc);
    push_word(0, 10'h258, acc);
    wait_pulses(2);
    repeat (20) step();
    check_eq("hold_blocks", pulses.size(), 2);
    REQ0_HOLD = 1'b0;
    wait_pulses(3);
    check_pulse("hold0", 0, 1'b0, 8'hC0);
    check_pulse("hold1", 1, 1'b1, 8'h58);
    check_pulse("hold2", 2, 1'b1, 8'h01);

    // Tie after a port-0 launch.
    send_checked(0, 10'h220);
    wait_idle();
    pulses.delete();
    REQ0_DATA = 10'h230;
    REQ1_DATA = 10'h231;
    REQ0_ENB  = 1'b1;
    REQ1_ENB  = 1'b1;
    step();
    REQ0_ENB = 1'b0;
    REQ1_ENB = 1'b0;
    wait_pulses(2);
`ifdef LCD_SCHED_ROUND_ROBIN_EN
    check_pulse("tie0", 0, 1'b1, 8'h31);
    check_pulse("tie1", 1, 1'b1, 8'h30);
`else
    check_pulse("tie0", 0, 1'b1, 8'h30);
    check_pulse("tie1", 1, 1'b1, 8'h31);
`endif

    send_checked(1, 10'h141);
    check_eq("bad_rdy1", REQ1_RDY, 1);

    for (int i = 0; i < 24; i++) begin
      w[9]   = 1'($urandom % 2);
      w[8]   = ($urandom % 6) == 0;
      w[7:0] = (($urandom % 4) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom % 256);
      repeat ($urandom % 3) step();
      send_checked(int'($urandom % 2), w);
    end

    // Reset in the middle of an E pulse.
    wait_idle();
    push_word(0, 10'h242, acc);
    r = 0;
    while (!LCD_E && r < 50) begin @(negedge CLK); r++; end
    if (r >= 50) check_eq("rst_pulse_timeout", 0, 1);
    #1 RST = 1'b1;
    #1;
    check_eq("midrst_e", LCD_E, 0);
    check_eq("midrst_done", INIT_DONE, 0);
    check_eq("midrst_rdy0", REQ0_RDY, 0);
    check_eq("midrst_rdy1", REQ1_RDY, 0);
    check_eq("midrst_err", ERR, 0);
    check_eq("midrst_db", LCD_DB, 0);
    step(); step();
    RST = 1'b0;
    r = cyc;
    err_seen = 1'b0;
    pulses.delete();
    check_init(r);
    send_checked(1, 10'h2A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
